// File: rtl/ram_bridge_pkg.sv
// ram_bridge_pkg: shared types and helpers for ram_wb_bridge.
//   state_e  - bridge FSM states
//   addr_hit - window decode for a 4*2**addr_w byte window at an aligned base
package ram_bridge_pkg;

    typedef enum logic [2:0] {
        StClear,
        StIdle,
        StWrite,
        StRdAddr,
        StRdData,
        StAck
    } state_e;

    // Compares only the bits above the word-address field and byte lanes.
    function automatic logic addr_hit(input logic [31:0] adr,
                                      input logic [31:0] base,
                                      input int unsigned addr_w);
        logic [31:0] mask;
        mask = 32'hFFFF_FFFF << (addr_w + 2);
        return ((adr ^ base) & mask) == 32'h0;
    endfunction

endpackage

// File: rtl/ram_wb_bridge.sv
// ram_wb_bridge: Wishbone classic slave owning the single port of a RAM128/RAM256 macro.
// Optionally zero-fills the macro after reset, then serves single reads/writes.
// Ports:
//   wb_clk_i, wb_rst_i           - clock, asynchronous active-high reset
//   wbs_cyc_i/stb_i/we_i/sel_i   - Wishbone request
//   wbs_adr_i/dat_i              - byte address, write data
//   wbs_ack_o/dat_o              - single-cycle ack, last read data
//   busy_o                       - zero-fill in progress
//   ram_en_o/a_o/di_o/we_o       - macro EN0, A0, Di0, WE0 (all registered)
//   ram_do_i                     - macro Do0
module ram_wb_bridge
    import ram_bridge_pkg::*;
#(
    parameter int unsigned ADDR_W         = 8,
    parameter logic [31:0] BASE_ADR       = 32'h3000_0000,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              wbs_cyc_i,
    input  logic              wbs_stb_i,
    input  logic              wbs_we_i,
    input  logic [3:0]        wbs_sel_i,
    input  logic [31:0]       wbs_adr_i,
    input  logic [31:0]       wbs_dat_i,
    output logic              wbs_ack_o,
    output logic [31:0]       wbs_dat_o,
    output logic              busy_o,
    output logic              ram_en_o,
    output logic [ADDR_W-1:0] ram_a_o,
    output logic [31:0]       ram_di_o,
    output logic [3:0]        ram_we_o,
    input  logic [31:0]       ram_do_i
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              done_q, done_d;
    logic              ack_q, ack_d;
    logic [31:0]       dat_q, dat_d;
    logic              en_q, en_d;
    logic [ADDR_W-1:0] a_q, a_d;
    logic [31:0]       di_q, di_d;
    logic [3:0]        we_q, we_d;
    logic              busy_q, busy_d;

    logic              hit;
    logic [ADDR_W-1:0] word_adr;

    assign hit      = wbs_cyc_i & wbs_stb_i & addr_hit(wbs_adr_i, BASE_ADR, ADDR_W);
    assign word_adr = wbs_adr_i[ADDR_W+1:2];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = done_q;
        ack_d   = 1'b0;
        dat_d   = dat_q;
        en_d    = en_q;
        a_d     = a_q;
        di_d    = di_q;
        we_d    = we_q;
        busy_d  = busy_q;

        unique case (state_q)
            StClear: begin
                if (done_q) begin
                    // Last word (DEPTH-1) is written by the macro at this edge.
                    en_d    = 1'b0;
                    we_d    = 4'h0;
                    busy_d  = 1'b0;
                    done_d  = 1'b0;
                    state_d = StIdle;
                end else begin
                    en_d   = 1'b1;
                    we_d   = 4'hF;
                    di_d   = 32'h0;
                    a_d    = cnt_q;
                    cnt_d  = cnt_q + 1'b1;
                    done_d = &cnt_q;
                end
            end
            StIdle: begin
                if (hit) begin
                    a_d  = word_adr;
                    en_d = 1'b1;
                    if (wbs_we_i) begin
                        we_d    = wbs_sel_i;
                        di_d    = wbs_dat_i;
                        state_d = StWrite;
                    end else begin
                        we_d    = 4'h0;
                        state_d = StRdAddr;
                    end
                end
            end
            StWrite: begin
                en_d    = 1'b0;
                we_d    = 4'h0;
                ack_d   = wbs_cyc_i;  // aborted cycles complete silently
                state_d = StAck;
            end
            StRdAddr: begin
                state_d = StRdData;
            end
            StRdData: begin
                dat_d   = ram_do_i;
                en_d    = 1'b0;
                ack_d   = wbs_cyc_i;
                state_d = StAck;
            end
            StAck: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q <= CLEAR_ON_RESET ? StClear : StIdle;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            ack_q   <= 1'b0;
            dat_q   <= 32'h0;
            en_q    <= 1'b0;
            a_q     <= '0;
            di_q    <= 32'h0;
            we_q    <= 4'h0;
            busy_q  <= CLEAR_ON_RESET;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            ack_q   <= ack_d;
            dat_q   <= dat_d;
            en_q    <= en_d;
            a_q     <= a_d;
            di_q    <= di_d;
            we_q    <= we_d;
            busy_q  <= busy_d;
        end
    end

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = dat_q;
    assign busy_o    = busy_q;
    assign ram_en_o  = en_q;
    assign ram_a_o   = a_q;
    assign ram_di_o  = di_q;
    assign ram_we_o  = we_q;

endmodule

// File: tb/tb_ram_wb_bridge.sv
// tb_ram_wb_bridge: self-checking bench for ram_wb_bridge paired with a RAM256 behavioural model.
module tb_ram_wb_bridge;

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned DEPTH  = 256;

    logic              clk;
    logic              rst;
    logic              cyc, stb, we;
    logic [3:0]        sel;
    logic [31:0]       adr, wdat;
    logic              ack;
    logic [31:0]       rdat;
    logic              busy;
    logic              ram_en;
    logic [ADDR_W-1:0] ram_a;
    logic [31:0]       ram_di;
    logic [3:0]        ram_we;
    logic [31:0]       ram_do;

    ram_wb_bridge #(
        .ADDR_W        (ADDR_W),
        .BASE_ADR      (32'h3000_0000),
        .CLEAR_ON_RESET(1'b1)
    ) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .wbs_cyc_i(cyc),
        .wbs_stb_i(stb),
        .wbs_we_i (we),
        .wbs_sel_i(sel),
        .wbs_adr_i(adr),
        .wbs_dat_i(wdat),
        .wbs_ack_o(ack),
        .wbs_dat_o(rdat),
        .busy_o   (busy),
        .ram_en_o (ram_en),
        .ram_a_o  (ram_a),
        .ram_di_o (ram_di),
        .ram_we_o (ram_we),
        .ram_do_i (ram_do)
    );

    // RAM256 model: synchronous port, byte write enables, registered Do0.
    logic [31:0] mem [DEPTH];
    logic        fill_rand;

    always @(posedge clk) begin
        if (fill_rand) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= $urandom;
        end else if (ram_en) begin
            for (int b = 0; b < 4; b++)
                if (ram_we[b]) mem[ram_a][8*b +: 8] <= ram_di[8*b +: 8];
            ram_do <= mem[ram_a];
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [31:0] rd_q[$];

    typedef struct {
        string       name;
        logic        we;
        logic [31:0] adr;
        logic [3:0]  sel;
        logic [31:0] dat;
        logic        exp_ack;
        logic [31:0] exp_rd;
        int          exp_edges;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic drive(input logic w, input logic [31:0] a, input logic [3:0] s,
                         input logic [31:0] d);
        cyc  = 1'b1;
        stb  = 1'b1;
        we   = w;
        adr  = a;
        sel  = s;
        wdat = d;
    endtask

    task automatic idle_bus();
        cyc = 1'b0;
        stb = 1'b0;
        we  = 1'b0;
    endtask

    // Called at posedge+1; returns at posedge+1 with the bridge back in IDLE.
    task automatic xfer(input vec_t v);
        logic [31:0] prev_dat;
        logic [31:0] exp_dat;
        int          edges;
        logic        got;
        logic        saw_en;
        prev_dat = rdat;
        edges    = 0;
        got      = 1'b0;
        saw_en   = 1'b0;
        drive(v.we, v.adr, v.sel, v.dat);
        if (v.exp_ack && !v.we) rd_q.push_back(v.exp_rd);
        while (edges < 8 && !got) begin
            @(posedge clk);
            edges++;
            #1;
            if (ram_en) saw_en = 1'b1;
            if (ack) got = 1'b1;
        end
        idle_bus();
        if (v.exp_ack) begin
            check({v.name, " ack"}, 32'(got), 32'd1);
            check({v.name, " edges"}, 32'(edges), 32'(v.exp_edges));
            if (!v.we) begin
                exp_dat = rd_q.pop_front();
                check({v.name, " rdata"}, rdat, exp_dat);
            end else begin
                check({v.name, " dat_hold"}, rdat, prev_dat);
            end
        end else begin
            check({v.name, " no_ack"}, 32'(got), 32'd0);
            check({v.name, " no_en"}, 32'(saw_en), 32'd0);
            check({v.name, " dat_hold"}, rdat, prev_dat);
        end
        @(posedge clk);
        #1;
        check({v.name, " ack_drop"}, 32'(ack), 32'd0);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, " ack"}, 32'(ack), 32'd0);
        check({tag, " dat"}, rdat, 32'h0);
        check({tag, " en"}, 32'(ram_en), 32'd0);
        check({tag, " a"}, 32'(ram_a), 32'd0);
        check({tag, " di"}, ram_di, 32'h0);
        check({tag, " we"}, 32'(ram_we), 32'd0);
        check({tag, " busy"}, 32'(busy), 32'd1);
    endtask

    vec_t tmp;

    initial begin
        int   n;
        logic got;

        vecs[0]  = '{"zero_fill_top", 1'b0, 32'h3000_03FC, 4'h0, 32'h0, 1'b1, 32'h0, 3};
        vecs[1]  = '{"wr_deadbeef", 1'b1, 32'h3000_0010, 4'hF, 32'hDEAD_BEEF, 1'b1, 32'h0, 2};
        vecs[2]  = '{"rd_deadbeef", 1'b0, 32'h3000_0010, 4'h0, 32'h0, 1'b1, 32'hDEAD_BEEF, 3};
        vecs[3]  = '{"wr_aabbccdd", 1'b1, 32'h3000_0020, 4'hF, 32'hAABB_CCDD, 1'b1, 32'h0, 2};
        vecs[4]  = '{"wr_sel0101", 1'b1, 32'h3000_0020, 4'b0101, 32'h1122_3344, 1'b1, 32'h0, 2};
        vecs[5]  = '{"rd_merged", 1'b0, 32'h3000_0020, 4'h0, 32'h0, 1'b1, 32'hAA22_CC44, 3};
        vecs[6]  = '{"wr_sel0", 1'b1, 32'h3000_0010, 4'h0, 32'h0, 1'b1, 32'h0, 2};
        vecs[7]  = '{"rd_byteoff", 1'b0, 32'h3000_0013, 4'h0, 32'h0, 1'b1, 32'hDEAD_BEEF, 3};
        vecs[8]  = '{"wr_word0", 1'b1, 32'h3000_0000, 4'hF, 32'h1234_5678, 1'b1, 32'h0, 2};
        vecs[9]  = '{"wr_miss400", 1'b1, 32'h3000_0400, 4'hF, 32'hFFFF_FFFF, 1'b0, 32'h0, 0};
        vecs[10] = '{"rd_miss400", 1'b0, 32'h3000_0400, 4'h0, 32'h0, 1'b0, 32'h0, 0};
        vecs[11] = '{"rd_word0", 1'b0, 32'h3000_0000, 4'h0, 32'h0, 1'b1, 32'h1234_5678, 3};
        vecs[12] = '{"wr_miss_lo", 1'b1, 32'h2000_0010, 4'hF, 32'h0BAD_0BAD, 1'b0, 32'h0, 0};
        vecs[13] = '{"rd_after_miss", 1'b0, 32'h3000_0010, 4'h0, 32'h0, 1'b1, 32'hDEAD_BEEF, 3};

        rst       = 1'b1;
        fill_rand = 1'b1;
        cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0; adr = 32'h0; wdat = 32'h0;
        @(posedge clk);
        @(posedge clk);
        #1;
        fill_rand = 1'b0;
        check_reset_vals("reset");

        // Zero-fill: count edges until busy falls.
        @(posedge clk);
        #1;
        rst = 1'b0;
        n = 0;
        while (busy && n < 400) begin
            @(posedge clk);
            n++;
            #1;
            if (n == 10) begin
                check("clear en", 32'(ram_en), 32'd1);
                check("clear we", 32'(ram_we), 32'hF);
                check("clear a", 32'(ram_a), 32'd9);
            end
        end
        check("clear busy edges", 32'(n), 32'(DEPTH + 1));
        check("clear en off", 32'(ram_en), 32'd0);

        for (int i = 0; i < 14; i++) xfer(vecs[i]);

        // Abort: drop cyc while the bridge is in WRITE.
        drive(1'b1, 32'h3000_0030, 4'hF, 32'hCAFE_F00D);
        @(posedge clk);
        #1;
        idle_bus();
        got = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            if (ack) got = 1'b1;
        end
        check("abort no_ack", 32'(got), 32'd0);
        tmp = '{"rd_after_abort", 1'b0, 32'h3000_0030, 4'h0, 32'h0, 1'b1, 32'hCAFE_F00D, 3};
        xfer(tmp);

        // Reset while in RD_ADDR, then a write held off through the clear.
        drive(1'b0, 32'h3000_0010, 4'h0, 32'h0);
        @(posedge clk);
        #1;
        check("rdaddr en", 32'(ram_en), 32'd1);
        rst = 1'b1;
        #1;
        check_reset_vals("midreset");
        idle_bus();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        n   = 0;
        got = 1'b0;
        repeat (5) begin
            @(posedge clk);
            n++;
            #1;
            if (ack) got = 1'b1;
        end
        drive(1'b1, 32'h3000_0040, 4'hF, 32'h5A5A_5A5A);
        while (!ack && n < 600) begin
            @(posedge clk);
            n++;
            #1;
        end
        check("held ack seen", 32'(ack), 32'd1);
        check("held ack busy", 32'(busy), 32'd0);
        check("held no early ack", 32'(got), 32'd0);
        check("held ack edges", 32'(n), 32'(DEPTH + 3));
        idle_bus();
        @(posedge clk);
        #1;
        tmp = '{"rd_held", 1'b0, 32'h3000_0040, 4'h0, 32'h0, 1'b1, 32'h5A5A_5A5A, 3};
        xfer(tmp);
        tmp = '{"rd_recleared", 1'b0, 32'h3000_0010, 4'h0, 32'h0, 1'b1, 32'h0, 3};
        xfer(tmp);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
